// File: rtl/k_ex_mem_stage_if.sv
// k_ex_mem_stage_if
//   Bundles the EX-side handshake/payload, the MEM-side handshake/payload and
//   the branch-resolution outputs of the EX->MEM stage.
//   master : environment view (drives EX payload, flush and MEM ready).
//   slave  : stage view (consumes EX payload, drives MEM payload and branch outputs).
interface k_ex_mem_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          K_flush;
   logic          K_ex_valid;
   logic          K_ex_ready;
   logic [DW-1:0] K_alu_result;
   logic          K_zero;
   logic [DW-1:0] K_rt_data;
   logic [RW-1:0] K_dest_reg;
   logic [DW-1:0] K_pc_plus4;
   logic [DW-1:0] K_branch_off;
   logic [5:0]    K_ctrl;
   logic          K_mem_valid;
   logic          K_mem_ready;
   logic [DW-1:0] K_mem_alu_result;
   logic [DW-1:0] K_mem_store_data;
   logic [RW-1:0] K_mem_dest_reg;
   logic [3:0]    K_mem_ctrl;
   logic          K_branch_taken;
   logic [DW-1:0] K_branch_target;

   modport master (
      output K_flush, K_ex_valid, K_alu_result, K_zero, K_rt_data, K_dest_reg,
             K_pc_plus4, K_branch_off, K_ctrl, K_mem_ready,
      input  K_ex_ready, K_mem_valid, K_mem_alu_result, K_mem_store_data,
             K_mem_dest_reg, K_mem_ctrl, K_branch_taken, K_branch_target
   );

   modport slave (
      input  K_flush, K_ex_valid, K_alu_result, K_zero, K_rt_data, K_dest_reg,
             K_pc_plus4, K_branch_off, K_ctrl, K_mem_ready,
      output K_ex_ready, K_mem_valid, K_mem_alu_result, K_mem_store_data,
             K_mem_dest_reg, K_mem_ctrl, K_branch_taken, K_branch_target
   );
endinterface

// File: rtl/k_ex_mem_stage.sv
// k_ex_mem_stage
//   EX->MEM pipeline register with a 2-entry skid buffer (head + skid) and
//   BEQ/BNE resolution from the ALU zero flag.
//   Ports:
//     K_clk   : rising-edge clock
//     K_rst_n : asynchronous active-low reset
//     bus     : k_ex_mem_stage_if.slave
//               EX side   : K_ex_valid/K_ex_ready, ALU result, zero, rt data,
//                           dest reg, pc+4, branch offset, 6-bit ctrl, K_flush
//               MEM side  : K_mem_valid/K_mem_ready, head entry payload
//               branch    : K_branch_taken one-cycle pulse, K_branch_target
//   K_ex_ready depends only on registered state, flush and reset, so a MEM
//   stall never forms a combinational path back into EX.
module k_ex_mem_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input logic             K_clk,
   input logic             K_rst_n,
   k_ex_mem_stage_if.slave bus
);

   typedef struct packed {
      logic [DW-1:0] alu;
      logic [DW-1:0] store;
      logic [RW-1:0] dest;
      logic [3:0]    ctrl;   // {reg_write, mem_to_reg, mem_read, mem_write}
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   entry_t        head, skid, in_entry;
   logic          load_head, load_skid, head_from_skid;
   logic          accept, pop;
   logic          mem_valid, skid_valid;
   logic          taken_c;
   logic [DW-1:0] target_c;
   logic          br_taken;
   logic [DW-1:0] br_target;

   assign mem_valid  = (state == ONE) || (state == FULL);
   assign skid_valid = (state == FULL);

   assign bus.K_ex_ready = ~skid_valid & ~bus.K_flush & K_rst_n;

   assign accept = bus.K_ex_valid & bus.K_ex_ready;
   assign pop    = mem_valid & bus.K_mem_ready;

   assign in_entry.alu   = bus.K_alu_result;
   assign in_entry.store = bus.K_rt_data;
   assign in_entry.dest  = bus.K_dest_reg;
   assign in_entry.ctrl  = bus.K_ctrl[5:2];

   // branch_eq and branch_ne both set is never produced by the decoder; the
   // OR form simply resolves it as taken-if-either.
   assign taken_c  = (bus.K_ctrl[1] & bus.K_zero) | (bus.K_ctrl[0] & ~bus.K_zero);
   assign target_c = bus.K_pc_plus4 + (bus.K_branch_off << 2);

   // Next-state and buffer-move decode
   always_comb begin
      state_nxt      = state;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
      if (bus.K_flush) begin
         // Flush wins over pop; accept is already blocked through K_ex_ready.
         state_nxt = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = ONE;
                  load_head = 1'b1;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  load_head = 1'b1;          // head replaced in place
               end else if (accept) begin
                  state_nxt = FULL;
                  load_skid = 1'b1;
               end else if (pop) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               // ready is low here, so only a pop can move things
               if (pop) begin
                  state_nxt      = ONE;
                  head_from_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge K_clk or negedge K_rst_n) begin
      if (!K_rst_n) begin
         state     <= EMPTY;
         head      <= '0;
         skid      <= '0;
         br_taken  <= 1'b0;
         br_target <= '0;
      end else begin
         state <= state_nxt;
         // Payload registers only move on a load; invalid entries keep stale data.
         if (head_from_skid)  head <= skid;
         else if (load_head)  head <= in_entry;
         if (load_skid)       skid <= in_entry;
         // A pulse already high during a flush simply ends; accept is 0 under
         // flush so no new pulse is launched.
         br_taken <= accept & taken_c;
         if (accept && taken_c) br_target <= target_c;
      end
   end

   assign bus.K_mem_valid      = mem_valid;
   assign bus.K_mem_alu_result = head.alu;
   assign bus.K_mem_store_data = head.store;
   assign bus.K_mem_dest_reg   = head.dest;
   assign bus.K_mem_ctrl       = mem_valid ? head.ctrl : 4'b0000;
   assign bus.K_branch_taken   = br_taken;
   assign bus.K_branch_target  = br_target;

endmodule
